// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD add/subtract block.
// Optional feature macro: SIGN_CORRECT_EN (adds the FIX state used to turn a
// ten's-complement subtraction result back into a magnitude).
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

`ifdef SIGN_CORRECT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } ctrl_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } ctrl_state_t;
`endif

endpackage

// File: rtl/bcd_digit_addsub.sv
// One-digit BCD adder with optional nine's complement of b, so the same
// logic serves addition, subtraction and ten's-complement-to-magnitude.
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       comp,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    bcd_digit_t b_eff;
    logic [4:0] raw;

    // Binary add of a, (optionally complemented) b and carry, then decimal fix-up
    always_comb begin
        b_eff = comp ? (BCD_MAX - b) : b;
        raw   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
        cout  = (raw > 5'd9);
        sum   = cout ? (raw[3:0] + BCD_CORR) : raw[3:0];
    end

endmodule

// File: rtl/bcd_serial_addsub_ctrl.sv
// Serial packed-BCD add/subtract sequencer: one digit per clock, LSD first,
// through a single shared bcd_digit_addsub instance.
// Optional feature macro: SIGN_CORRECT_EN -- negative differences are
// re-complemented in a FIX pass and reported as magnitude with neg=1.
module bcd_serial_addsub_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   op_a,
    input  logic [4*DIGITS-1:0]   op_b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  neg,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    ctrl_state_t   state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          mode_r;

    bcd_digit_t    dp_a;
    bcd_digit_t    dp_b;
    logic          dp_comp;
    bcd_digit_t    dp_sum;
    logic          dp_cout;

    logic          accept;

    assign accept = (state == IDLE) && start;

    // Flags any nibble outside 0..9
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*4 +: 4] > BCD_MAX) bad = 1'b1;
        end
        return bad;
    endfunction

    // Select datapath operands: operand digits in RUN, stored result in FIX
    always_comb begin
        dp_a    = a_r[int'(idx)*4 +: 4];
        dp_b    = b_r[int'(idx)*4 +: 4];
        dp_comp = mode_r;
`ifdef SIGN_CORRECT_EN
        if (state == FIX) begin
            dp_a    = '0;
            dp_b    = result[int'(idx)*4 +: 4];
            dp_comp = 1'b1;
        end
`endif
    end

    bcd_digit_addsub u_digit (
        .a    (dp_a),
        .b    (dp_b),
        .comp (dp_comp),
        .cin  (carry),
        .sum  (dp_sum),
        .cout (dp_cout)
    );

    // Operand capture on an accepted start; data only, so no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r    <= op_a;
            b_r    <= op_b;
            mode_r <= mode;
        end
    end

    // Sequencer: IDLE accepts work, RUN walks digits, FIX restores magnitude
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            neg    <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err   <= has_bad_digit(op_a) | has_bad_digit(op_b);
                        idx   <= '0;
                        carry <= mode;
                        cout  <= 1'b0;
                        neg   <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result[int'(idx)*4 +: 4] <= dp_sum;
                    carry <= dp_cout;
                    if (idx == LAST) begin
                        cout <= dp_cout;
                        idx  <= '0;
`ifdef SIGN_CORRECT_EN
                        if (mode_r && !dp_cout) begin
                            carry <= 1'b1;
                            state <= FIX;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
`else
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
`ifdef SIGN_CORRECT_EN
                FIX: begin
                    result[int'(idx)*4 +: 4] <= dp_sum;
                    carry <= dp_cout;
                    if (idx == LAST) begin
                        idx   <= '0;
                        neg   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Directed bench for bcd_serial_addsub_ctrl (DIGITS=4): vector table plus
// hand sequences for ignored start, mid-run reset and back-to-back starts.
module tb_bcd_serial_addsub_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MAXLAT = 40;

`ifdef SIGN_CORRECT_EN
    localparam int NEG_LAT = 2 * DIGITS;
`else
    localparam int NEG_LAT = DIGITS;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         neg;
    logic         err;

    int checks;
    int failures;

    typedef struct {
        string        name;
        logic         mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         chk_res;
        logic [W-1:0] res;
        logic         cout;
        logic         neg;
        logic         err;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    bcd_serial_addsub_ctrl #(.DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .neg    (neg),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present a start for one edge; returns #1 after the accepting edge
    task automatic launch(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        mode  = m;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen (sampled #1 after each edge)
    task automatic wait_done(input string name, output int lat);
        lat = 0;
        for (int n = 1; n <= MAXLAT; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done_within_%0d", name, MAXLAT);
        end
    endtask

    initial begin
        int lat;

        checks   = 0;
        failures = 0;
        start    = 1'b0;
        mode     = 1'b0;
        op_a     = '0;
        op_b     = '0;

        //               name        mode  a         b        chk   res       cout  neg   err   lat
        vecs[0] = '{"add_1234_5678", 1'b0, 16'h1234, 16'h5678, 1'b1, 16'h6912, 1'b0, 1'b0, 1'b0, DIGITS};
        vecs[1] = '{"add_9999_0001", 1'b0, 16'h9999, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, DIGITS};
        vecs[2] = '{"sub_5000_1234", 1'b1, 16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 1'b0, DIGITS};
`ifdef SIGN_CORRECT_EN
        vecs[3] = '{"sub_1234_5000", 1'b1, 16'h1234, 16'h5000, 1'b1, 16'h3766, 1'b0, 1'b1, 1'b0, NEG_LAT};
        vecs[4] = '{"sub_0001_0002", 1'b1, 16'h0001, 16'h0002, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, NEG_LAT};
`else
        vecs[3] = '{"sub_1234_5000", 1'b1, 16'h1234, 16'h5000, 1'b1, 16'h6234, 1'b0, 1'b0, 1'b0, NEG_LAT};
        vecs[4] = '{"sub_0001_0002", 1'b1, 16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, NEG_LAT};
`endif
        vecs[5] = '{"sub_0500_0500", 1'b1, 16'h0500, 16'h0500, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, DIGITS};
        vecs[6] = '{"add_9999_9999", 1'b0, 16'h9999, 16'h9999, 1'b1, 16'h9998, 1'b1, 1'b0, 1'b0, DIGITS};
        vecs[7] = '{"add_4567_1111", 1'b0, 16'h4567, 16'h1111, 1'b1, 16'h5678, 1'b0, 1'b0, 1'b0, DIGITS};
        vecs[8] = '{"err_123A",      1'b0, 16'h123A, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, DIGITS};
        vecs[9] = '{"err_clear",     1'b0, 16'h0021, 16'h0012, 1'b1, 16'h0033, 1'b0, 1'b0, 1'b0, DIGITS};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   busy,   0);
        check("rst_done",   done,   0);
        check("rst_result", result, 0);
        check("rst_cout",   cout,   0);
        check("rst_neg",    neg,    0);
        check("rst_err",    err,    0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven operations
        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].mode, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_busy"}, busy, 1);
            check({vecs[i].name, "_done_early"}, done, 0);
            wait_done(vecs[i].name, lat);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            if (vecs[i].chk_res)
                check({vecs[i].name, "_result"}, result, vecs[i].res);
            check({vecs[i].name, "_cout"}, cout, vecs[i].cout);
            check({vecs[i].name, "_neg"},  neg,  vecs[i].neg);
            check({vecs[i].name, "_err"},  err,  vecs[i].err);
            check({vecs[i].name, "_busy_end"}, busy, 0);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_done_pulse"}, done, 0);
        end

        // Start while busy is ignored
        launch(1'b0, 16'h1234, 16'h5678);
        @(posedge clk);
        #1;
        mode  = 1'b1;
        op_a  = 16'h9999;
        op_b  = 16'h9999;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_ignore", lat);
        check("busy_ignore_lat",    lat + 2, DIGITS);
        check("busy_ignore_result", result, 16'h6912);
        check("busy_ignore_cout",   cout, 0);
        @(posedge clk);
        #1;
        check("busy_ignore_not_queued", busy, 0);

        // Asynchronous reset mid-RUN
        launch(1'b1, 16'h5000, 16'h1234);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("midrst_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy",   busy,   0);
        check("midrst_result", result, 0);
        check("midrst_cout",   cout,   0);
        check("midrst_done",   done,   0);
        @(negedge clk);
        rst = 1'b0;
        launch(1'b0, 16'h1234, 16'h5678);
        wait_done("after_rst", lat);
        check("after_rst_lat",    lat, DIGITS);
        check("after_rst_result", result, 16'h6912);

        // Back-to-back: start held during the done cycle
        launch(1'b0, 16'h0005, 16'h0005);
        wait_done("b2b_first", lat);
        check("b2b_first_result", result, 16'h0010);
        mode  = 1'b1;
        op_a  = 16'h1234;
        op_b  = 16'h5000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_done_drop", done, 0);
        check("b2b_busy_rise", busy, 1);
        wait_done("b2b_second", lat);
        check("b2b_second_lat", lat, NEG_LAT);
`ifdef SIGN_CORRECT_EN
        check("b2b_second_result", result, 16'h3766);
        check("b2b_second_neg",    neg, 1);
`else
        check("b2b_second_result", result, 16'h6234);
        check("b2b_second_neg",    neg, 0);
`endif
        check("b2b_second_cout", cout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_serial_addsub_ctrl.md
# bcd_serial_addsub_ctrl

Sequencer that performs multi-digit packed-BCD addition or subtraction by time-sharing a single one-digit BCD adder/subtractor datapath, one digit per clock, least-significant digit first. It accepts a start pulse with two operands and a mode bit, walks the digits while propagating the decimal carry, and returns a registered result with a one-cycle done pulse. It sits between the control/keypad logic and the display path, replacing a wide combinational ripple of digit adders.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- mode  input  1  0 = A+B, 1 = A−B
- op_a  input  4*DIGITS  packed BCD operand A, digit 0 in bits [3:0]
- op_b  input  4*DIGITS  packed BCD operand B
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result valid
- result  output  4*DIGITS  packed BCD result, held until next accepted start
- cout  output  1  final decimal carry
- neg  output  1  result is a negative magnitude (0 unless SIGN_CORRECT_EN)
- err  output  1  some operand digit > 9 at start

## Operation
- States: IDLE, RUN, FIX (only with SIGN_CORRECT_EN).
- IDLE: start=1 captures op_a, op_b, mode, and err = any digit > 9. Sets digit index to 0, carry to mode, and goes to RUN. Clears done, neg, and cout.
- RUN: each cycle, digit i is computed as A[i] + (mode ? 9−B[i] : B[i]) + carry, then decimal-corrected (sum > 9 → +6, carry out = 1). The digit is written into result[i], the carry is updated, and i increments.
- After digit DIGITS−1: cout = final carry.
  - If SIGN_CORRECT_EN, mode=1 and carry=0: go to FIX with i=0 and carry=1.
  - Otherwise: done=1 for one cycle and go to IDLE.
- FIX: each cycle, result[i] = (9−result[i]) + carry, decimal-corrected; this is ten's complement to magnitude. After the last digit: neg=1, done=1, go to IDLE. cout stays 0.
- Subtraction semantics: cout=1 means A ≥ B. Without correction, cout=0 means the result is in ten's-complement form.
- Non-BCD digits are processed anyway; the output is undefined but deterministic. err stays set until the next accepted start.
- start while busy=1 is ignored and not queued.
- No division of the datapath: one digit operation per cycle, no other sharing.

## Timing
- Reset values: busy=0, done=0, result=0, cout=0, neg=0, err=0, state IDLE.
- Start accepted at edge E0. busy=1 from after E0.
- Digits written at edges E1..E_DIGITS.
- Plain operation: done=1 and busy=0 in the cycle after E_DIGITS. Latency is DIGITS edges after acceptance.
- Corrected operation: FIX digits are written at E_{DIGITS+1}..E_{2·DIGITS}, and done follows E_{2·DIGITS}.
- Back-to-back: start high during the done cycle is accepted at the next edge. done drops and busy rises.
- Asynchronous rst at any point, including mid-RUN or FIX, immediately forces the reset values. A partial result is discarded.

## Configuration
- SIGN_CORRECT_EN defined: FIX state is present, and negative subtraction results are returned as magnitude with neg=1.
- SIGN_CORRECT_EN undefined: no FIX state, neg tied to 0, and negative results are left in ten's-complement form with cout=0.

## Structure
- Shared package bcd_pkg holds:
  - the 4-bit bcd_digit_t typedef
  - the controller state enum
  - constants BCD_MAX=9 and BCD_CORR=6
- One combinational sub-module, bcd_digit_addsub:
  - inputs: a, b, comp (nine's-complement b), cin
  - outputs: sum digit, cout
  - the same instance is used in RUN (a=A[i], b=B[i], comp=mode) and in FIX (a=0, b=result[i], comp=1).

## Test plan
- DIGITS=4, mode=0, 1234+5678 → result 6912, cout=0, done one cycle after the 4th digit edge.
- mode=0, 9999+0001 → result 0000, cout=1; the carry ripples through all digits.
- mode=1, 5000−1234 → result 3766, cout=1, neg=0.
- mode=1, 1234−5000:
  - without the macro → result 6234, cout=0, done after 4 edges
  - with SIGN_CORRECT_EN → result 3766, neg=1, done after 8 edges
- start pulsed again two cycles into a busy operation → ignored, first result unchanged. rst asserted mid-RUN → all outputs zero immediately, and a subsequent start computes correctly.
- op_a digit 0xA at start → err=1 with done still produced; the next start with valid operands clears err.
